banked_data_memory: RTL and testbench
=====================================

# banked_data_memory

Parametrised, byte-lane-banked single-port data memory for the multicycle processor, successor to the fixed 32×16 word memory. Adds configurable width/depth, byte or word access with sign-extended byte loads, a req/ready handshake with configurable pipelined read latency, misaligned-access detection, and a hardware init sequencer. The init sequencer loads the two boot words and zero-fills the rest after every reset. It sits between the datapath's memory-address/data registers and the control FSM.

## Interface
- DATA_W, 16 — word width; legal values are 16 or 32. LANES = DATA_W/8.
- ADDR_W, 6 — byte-address width. DEPTH = 2**ADDR_W / LANES words.
- RD_LAT, 1 — read latency in cycles; legal values are 1 or 2.
- BOOT_W0, 16'b0000001011110000 — word 0 image, zero-extended to DATA_W.
- BOOT_W1, 16'b0010001011101000 — word 1 image, zero-extended to DATA_W.

Ports:
- clk  in  1  — single clock; all state on the rising edge.
- proc_rst  in  1  — reset, asynchronous and active-high.
- req  in  1  — access request.
- we  in  1  — 1 = write, 0 = read; sampled with req.
- byte_mode  in  1  — 1 = byte access, 0 = word access.
- addr  in  ADDR_W  — byte address.
- wdata  in  DATA_W  — write data. Byte mode uses wdata[7:0].
- ready  out  1  — block can accept a request this cycle.
- rvalid  out  1  — rdata valid, one-cycle pulse per read.
- rdata  out  DATA_W  — read data.
- err  out  1  — misaligned-access pulse.
- init_done  out  1  — init sequence complete; stays high until the next reset.

## Operation
- States: INIT → IDLE. There are no other states; reads are pipelined, not stateful.
- Reset asserted: ready, rvalid, rdata, err and init_done all go to 0 immediately. The init counter is cleared to 0 and state is forced to INIT.
- INIT:
  - Writes one word per cycle at index = counter: BOOT_W0 at word 0, BOOT_W1 at word 1, zero elsewhere.
  - Runs DEPTH cycles, then enters IDLE and sets ready=1 and init_done=1.
  - req is ignored while in INIT.
- Accept condition: req && ready. In IDLE, ready is always 1; back-to-back requests are accepted every cycle.
- Word index is addr[ADDR_W-1:log2(LANES)]; the lane is addr[log2(LANES)-1:0].
- Word write: all lanes are written with wdata.
- Byte write: only the addressed lane is written, with wdata[7:0]. Other lanes are unchanged.
- Word read: rdata = the full word.
- Byte read: rdata = {{(DATA_W-8){lane[7]}}, lane}, i.e. sign-extended.
- Misaligned access is a word access with nonzero lane bits:
  - No array update and no rvalid.
  - err pulses one cycle, at the cycle rvalid would have occurred. For writes, that is 1 cycle after accept.
- Byte accesses are never misaligned.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the new data. Lanes not written return their old data.
- Reset mid-operation: in-flight reads are dropped (no rvalid) and INIT restarts from word 0.

## Timing
- Write: the array updates at the accept edge.
- Read: rvalid and rdata are registered and asserted RD_LAT cycles after the accept edge.
- RD_LAT=2 adds one output register stage.
- rdata holds its last value when rvalid=0. It is not cleared except by reset.
- Throughput is one access per cycle; RD_LAT reads may be in flight at once.
- Init duration is exactly DEPTH cycles after reset deasserts. Defaults give 32 cycles, so ready first samples high at the 33rd rising edge after deassert.

## Structure
- Package mem_pkg holds:
  - the state enum (INIT, IDLE),
  - the localparam functions LANES and DEPTH and the lane-select width,
  - the default boot-word constants.
- Sub-module mem_lane: an 8-bit × DEPTH bank with a write enable and a registered read. It is instantiated LANES times.
- The top level holds the init FSM, lane decode, alignment check, sign extension and the RD_LAT pipeline.

## Test plan
All scenarios use default parameters unless stated.
- Reset, then wait 32 cycles → ready=0 throughout. init_done=1 at the 33rd edge. Word reads of addr 0, 2 and 4 return 0x02F0, 0x22E8 and 0x0000, with rvalid 1 cycle after accept.
- Word write 0xA5C3 to addr 6, then byte write 0x7E to addr 7, then word read addr 6 → rdata=0x7EC3. Byte read addr 6 → 0xFFC3; byte read addr 7 → 0x007E.
- Word write to addr 5 → err pulses 1 cycle later and word 2 is unchanged. Word read addr 3 → err pulse and no rvalid.
- Back-to-back reads of addrs 0, 2 and 4 on consecutive cycles with RD_LAT=2 → rvalid on cycles +2, +3, +4 with rdata 0x02F0, 0x22E8, 0x0000.
- Assert proc_rst one cycle after a read is accepted → rvalid never pulses. Outputs are 0 at once, and init repeats for the full 32 cycles.
- DATA_W=32, ADDR_W=7 → init takes 32 cycles. Byte write 0x80 to addr 3, then byte read addr 3 → rdata=0xFFFFFF80.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and geometry helpers for the byte-lane-banked data memory.
package mem_pkg;

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  localparam logic [15:0] BOOT_W0_DEFAULT = 16'b0000001011110000;
  localparam logic [15:0] BOOT_W1_DEFAULT = 16'b0010001011101000;

  function automatic int unsigned lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned depth(input int unsigned addr_w, input int unsigned data_w);
    return (2 ** addr_w) / lanes(data_w);
  endfunction

  function automatic int unsigned lane_sel_w(input int unsigned data_w);
    return $clog2(lanes(data_w));
  endfunction

endpackage

// File: rtl/banked_data_memory_if.sv
// Request/response bus between the datapath/control FSM and the data memory.
interface banked_data_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic              req;
  logic              we;
  logic              byte_mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              init_done;

  modport master (
    output req, we, byte_mode, addr, wdata,
    input  ready, rvalid, rdata, err, init_done
  );

  modport slave (
    input  req, we, byte_mode, addr, wdata,
    output ready, rvalid, rdata, err, init_done
  );
endinterface

// File: rtl/mem_lane.sv
// One 8-bit byte-lane bank with synchronous write and registered read.
module mem_lane #(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_data_memory.sv
// Banked data memory: init sequencer, lane decode, alignment check,
// sign extension and the RD_LAT-deep read output pipeline.
module banked_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned RD_LAT  = 1,
  parameter logic [15:0] BOOT_W0 = BOOT_W0_DEFAULT,
  parameter logic [15:0] BOOT_W1 = BOOT_W1_DEFAULT
) (
  input logic clk,
  input logic proc_rst,
  banked_data_memory_if.slave bus
);

  localparam int unsigned LANES  = lanes(DATA_W);
  localparam int unsigned DEPTH  = depth(ADDR_W, DATA_W);
  localparam int unsigned LSEL_W = lane_sel_w(DATA_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              ready_q;
  logic              init_done_q;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              s1_rd_q;
  logic              s1_rd_err_q;
  logic              s1_wr_err_q;
  logic              s1_byte_q;
  logic [LSEL_W-1:0] s1_lane_q;

  logic              acc_c;
  logic              misalign_c;
  logic              rd_acc_c;
  logic [LSEL_W-1:0] lane_c;
  logic [IDX_W-1:0]  widx_c;
  logic [IDX_W-1:0]  lane_addr_c;
  logic [DATA_W-1:0] init_word_c;
  logic [LANES-1:0]  lane_we_c;
  logic [LANES-1:0][7:0] lane_wd_c;
  logic [LANES-1:0][7:0] lane_rd;
  logic [7:0]        byte_c;
  logic [DATA_W-1:0] fmt_c;

  logic              out_rd_c;
  logic              out_rd_err_c;
  logic [DATA_W-1:0] out_data_c;

  // Request decode; in INIT all lanes are overwritten with the boot image.
  always_comb begin
    lane_c      = bus.addr[LSEL_W-1:0];
    widx_c      = bus.addr[ADDR_W-1:LSEL_W];
    acc_c       = bus.req && ready_q;
    misalign_c  = !bus.byte_mode && (lane_c != '0);
    rd_acc_c    = acc_c && !bus.we && !misalign_c;
    init_word_c = '0;
    lane_we_c   = '0;
    lane_wd_c   = '0;
    if (cnt_q == IDX_W'(0))      init_word_c = DATA_W'(BOOT_W0);
    else if (cnt_q == IDX_W'(1)) init_word_c = DATA_W'(BOOT_W1);
    lane_addr_c = (state_q == INIT) ? cnt_q : widx_c;
    for (int i = 0; i < LANES; i++) begin
      if (state_q == INIT) begin
        lane_we_c[i] = 1'b1;
        lane_wd_c[i] = init_word_c[8*i +: 8];
      end else begin
        lane_we_c[i] = acc_c && bus.we && !misalign_c &&
                       (!bus.byte_mode || (lane_c == LSEL_W'(i)));
        lane_wd_c[i] = bus.byte_mode ? bus.wdata[7:0] : bus.wdata[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_lane #(.DEPTH(DEPTH)) u_lane (
      .clk     (clk),
      .we_i    (lane_we_c[g]),
      .re_i    (rd_acc_c),
      .addr_i  (lane_addr_c),
      .wdata_i (lane_wd_c[g]),
      .rdata_o (lane_rd[g])
    );
  end

  // Init sequencer: one word per cycle, then IDLE with ready held high.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        IDLE: ready_q <= 1'b1;
      endcase
    end
  end

  // Side-band stage aligned with the lane read registers.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      s1_rd_q     <= 1'b0;
      s1_rd_err_q <= 1'b0;
      s1_wr_err_q <= 1'b0;
      s1_byte_q   <= 1'b0;
      s1_lane_q   <= '0;
    end else begin
      s1_rd_q     <= rd_acc_c;
      s1_rd_err_q <= acc_c && !bus.we && misalign_c;
      s1_wr_err_q <= acc_c && bus.we && misalign_c;
      if (rd_acc_c) begin
        s1_byte_q <= bus.byte_mode;
        s1_lane_q <= lane_c;
      end
    end
  end

  always_comb begin
    byte_c = lane_rd[s1_lane_q];
    fmt_c  = s1_byte_q ? {{(DATA_W-8){byte_c[7]}}, byte_c} : DATA_W'(lane_rd);
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_rd_q;
    logic              s2_rd_err_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk or posedge proc_rst) begin
      if (proc_rst) begin
        s2_rd_q     <= 1'b0;
        s2_rd_err_q <= 1'b0;
        s2_data_q   <= '0;
      end else begin
        s2_rd_q     <= s1_rd_q;
        s2_rd_err_q <= s1_rd_err_q;
        if (s1_rd_q) s2_data_q <= fmt_c;
      end
    end

    assign out_rd_c     = s2_rd_q;
    assign out_rd_err_c = s2_rd_err_q;
    assign out_data_c   = s2_data_q;
  end else begin : g_lat1
    assign out_rd_c     = s1_rd_q;
    assign out_rd_err_c = s1_rd_err_q;
    assign out_data_c   = fmt_c;
  end

  // Write misalignment always reports one cycle after accept; reads at RD_LAT.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= out_rd_c;
      err_q    <= out_rd_err_c | s1_wr_err_q;
      if (out_rd_c) rdata_q <= out_data_c;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_banked_data_memory.sv
// Scoreboard bench: a 16-bit/RD_LAT=1 and a 32-bit/RD_LAT=2 instance share stimulus
// and are each checked against a byte-array reference model.
module tb_banked_data_memory;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        proc_rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        bm = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] wdata = '0;

  int pcnt = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] mem [2][128];
  rd_t rdq0[$];
  rd_t rdq1[$];
  int  errq0[$];
  int  errq1[$];

  banked_data_memory_if #(.DATA_W(16), .ADDR_W(6)) ifa ();
  banked_data_memory_if #(.DATA_W(32), .ADDR_W(7)) ifb ();

  assign ifa.req = req;  assign ifa.we = we;  assign ifa.byte_mode = bm;
  assign ifa.addr = addr[5:0];  assign ifa.wdata = wdata[15:0];
  assign ifb.req = req;  assign ifb.we = we;  assign ifb.byte_mode = bm;
  assign ifb.addr = addr;  assign ifb.wdata = wdata;

  banked_data_memory #(.DATA_W(16), .ADDR_W(6), .RD_LAT(1)) dut_a (
    .clk(clk), .proc_rst(proc_rst), .bus(ifa.slave));
  banked_data_memory #(.DATA_W(32), .ADDR_W(7), .RD_LAT(2)) dut_b (
    .clk(clk), .proc_rst(proc_rst), .bus(ifb.slave));

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, pcnt);
    end
  endtask

  // Reference model: byte-addressed array, lanes little-endian within a word.
  task automatic model(input int id, input bit w, input bit b, input logic [6:0] a,
                       input logic [31:0] d);
    int l, lat, ba, lane, word;
    logic [31:0] v;
    rd_t r;
    l    = (id == 0) ? 2 : 4;
    lat  = (id == 0) ? 1 : 2;
    ba   = (id == 0) ? int'(a[5:0]) : int'(a);
    lane = ba % l;
    word = ba / l;
    if (!b && lane != 0) begin
      if (id == 0) errq0.push_back(pcnt + 1 + (w ? 1 : lat));
      else         errq1.push_back(pcnt + 1 + (w ? 1 : lat));
    end else if (w) begin
      if (b) mem[id][ba] = d[7:0];
      else for (int i = 0; i < l; i++) mem[id][word*l + i] = d[8*i +: 8];
    end else begin
      v = '0;
      if (b) begin
        v = 32'(mem[id][ba]);
        if (v[7]) v = v | 32'hFFFF_FF00;
      end else begin
        for (int i = 0; i < l; i++) v[8*i +: 8] = mem[id][word*l + i];
      end
      if (l == 2) v = v & 32'h0000_FFFF;
      r.due  = pcnt + 1 + lat;
      r.data = v;
      if (id == 0) rdq0.push_back(r);
      else         rdq1.push_back(r);
    end
  endtask

  task automatic model_init();
    for (int id = 0; id < 2; id++)
      for (int i = 0; i < 128; i++) mem[id][i] = 8'h00;
    mem[0][0] = 8'hF0; mem[0][1] = 8'h02; mem[0][2] = 8'hE8; mem[0][3] = 8'h22;
    mem[1][0] = 8'hF0; mem[1][1] = 8'h02; mem[1][4] = 8'hE8; mem[1][5] = 8'h22;
  endtask

  task automatic issue(input bit w, input bit b, input logic [6:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req = 1'b1; we = w; bm = b; addr = a; wdata = d;
    model(0, w, b, a, d);
    model(1, w, b, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req = 1'b0;
    end
  endtask

  // Monitor: per cycle, compare DUT responses with whatever falls due now.
  task automatic mon(input int id, input logic rv, input logic er, input logic [31:0] d);
    bit exp_rv, exp_er;
    logic [31:0] exp_d;
    rd_t r;
    exp_rv = 1'b0; exp_er = 1'b0; exp_d = '0;
    if (id == 0) begin
      if (rdq0.size() > 0 && rdq0[0].due == pcnt) begin
        r = rdq0.pop_front(); exp_rv = 1'b1; exp_d = r.data;
      end
      while (errq0.size() > 0 && errq0[0] == pcnt) begin
        void'(errq0.pop_front()); exp_er = 1'b1;
      end
    end else begin
      if (rdq1.size() > 0 && rdq1[0].due == pcnt) begin
        r = rdq1.pop_front(); exp_rv = 1'b1; exp_d = r.data;
      end
      while (errq1.size() > 0 && errq1[0] == pcnt) begin
        void'(errq1.pop_front()); exp_er = 1'b1;
      end
    end
    if (exp_rv || rv) begin
      chk($sformatf("rvalid[%0d]", id), 32'(rv), 32'(exp_rv));
      if (exp_rv && rv) chk($sformatf("rdata[%0d]", id), d, exp_d);
    end
    if (exp_er || er) chk($sformatf("err[%0d]", id), 32'(er), 32'(exp_er));
  endtask

  always @(negedge clk) begin
    if (!proc_rst) begin
      mon(0, ifa.rvalid, ifa.err, {16'h0, ifa.rdata});
      mon(1, ifb.rvalid, ifb.err, ifb.rdata);
    end
  end

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    proc_rst = 1'b1;
    req = 1'b0;
    #1;
    chk("rst_ready_a", 32'(ifa.ready), 0);      chk("rst_ready_b", 32'(ifb.ready), 0);
    chk("rst_rvalid_a", 32'(ifa.rvalid), 0);    chk("rst_rvalid_b", 32'(ifb.rvalid), 0);
    chk("rst_err_a", 32'(ifa.err), 0);          chk("rst_err_b", 32'(ifb.err), 0);
    chk("rst_init_done_a", 32'(ifa.init_done), 0);
    chk("rst_init_done_b", 32'(ifb.init_done), 0);
    chk("rst_rdata_a", {16'h0, ifa.rdata}, 0);  chk("rst_rdata_b", ifb.rdata, 0);
    rdq0.delete(); rdq1.delete(); errq0.delete(); errq1.delete();
    repeat (hold) @(posedge clk);
    #1 proc_rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("init_ready_a@%0d", k), 32'(ifa.ready), 0);
      chk($sformatf("init_ready_b@%0d", k), 32'(ifb.ready), 0);
    end
    @(negedge clk);
    chk("ready_a@33", 32'(ifa.ready), 1);          chk("ready_b@33", 32'(ifb.ready), 1);
    chk("init_done_a@33", 32'(ifa.init_done), 1);  chk("init_done_b@33", 32'(ifb.init_done), 1);
    model_init();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3);
    // Boot image, back-to-back word reads.
    issue(0, 0, 7'd0, '0); issue(0, 0, 7'd2, '0); issue(0, 0, 7'd4, '0);
    idle(4);
    // Word write, partial byte overwrite, word and sign-extended byte reads.
    issue(1, 0, 7'd6, 32'hA5C3); issue(1, 1, 7'd7, 32'h7E);
    issue(0, 0, 7'd6, '0); issue(0, 1, 7'd6, '0); issue(0, 1, 7'd7, '0);
    idle(3);
    // Misaligned word write and read, then confirm the target word is intact.
    issue(1, 0, 7'd5, 32'h1234_5678); issue(0, 0, 7'd4, '0); issue(0, 0, 7'd3, '0);
    idle(3);
    issue(1, 1, 7'd3, 32'h80); issue(0, 1, 7'd3, '0);
    idle(4);
    // Reset right after a read is accepted drops it.
    issue(0, 0, 7'd0, '0);
    do_reset(2);
    issue(0, 0, 7'd2, '0);
    idle(3);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 7'($urandom_range(0, 127)), $urandom);
    end
    idle(6);
    chk("queues_drained", 32'(rdq0.size() + rdq1.size() + errq0.size() + errq1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
